reg_file_mp: RTL and testbench

//   Parametrised multi-port register file, the successor to the CPUv1 single-write regfile.
//   Two combinational read ports and two write ports with fixed priority.
//   x0 is hardwired to zero. Optional same-cycle write-to-read bypass.
//   A reset-driven clear sequencer zeroes the array one entry per cycle.

---
 rtl/reg_file_mp.sv | 112 +++++++++++
 tb/tb_reg_file_mp.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_mp : 2-read / 2-write register file, x0 = 0, reset clear  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            we0,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            we1,
  output logic            busy,
  output logic            wr_conflict
);

  localparam int NREGS = 2 ** AW;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Power-up values model the "before first reset" condition: running, array zero.
  state_t          state = RUN;
  state_t          state_next;
  logic [AW-1:0]   clr_cnt = '0;
  logic [AW-1:0]   clr_cnt_next;
  logic            conflict_q = 1'b0;
  logic            conflict_next;
  logic [XLEN-1:0] regs [NREGS] = '{default: '0};

  logic            wr0;
  logic            wr1;
  logic [AW-1:0]   raddr [2];
  logic [XLEN-1:0] rdata [2];

  assign busy        = (state == CLEAR);
  assign wr_conflict = conflict_q;
  assign wr0         = !busy && we0 && (waddr0 != '0);
  assign wr1         = !busy && we1 && (waddr1 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_cnt    <= AW'(1);
      conflict_q <= 1'b0;
    end else begin
      state      <= state_next;
      clr_cnt    <= clr_cnt_next;
      conflict_q <= conflict_next;
    end
  end

  always_comb begin
    state_next    = state;
    clr_cnt_next  = clr_cnt;
    conflict_next = 1'b0;
    case (state)
      CLEAR: begin
        clr_cnt_next = clr_cnt + AW'(1);
        if (clr_cnt == '1) begin
          state_next = RUN;
        end
      end
      default: begin
        conflict_next = we0 && we1 && (waddr0 == waddr1) && (waddr0 != '0);
      end
    endcase
  end

  // Port 1 is assigned last so it wins when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        regs[clr_cnt] <= '0;
      end else begin
        if (wr0) regs[waddr0] <= wdata0;
        if (wr1) regs[waddr1] <= wdata1;
      end
    end
  end

  assign raddr[0] = raddr0;
  assign raddr[1] = raddr1;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit0;
    logic hit1;
    assign hit1     = BYPASS && we1 && (waddr1 == raddr[p]);
    assign hit0     = BYPASS && we0 && (waddr0 == raddr[p]);
    assign rdata[p] = ((raddr[p] == '0) || busy) ? '0 :
                      hit1                       ? wdata1 :
                      hit0                       ? wdata0 :
                                                   regs[raddr[p]];
  end

  assign rdata0 = rdata[0];
  assign rdata1 = rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// tb_reg_file_mp : directed scenarios on 32/5 (bypass and no-bypass) plus
// randomized dual-port traffic on a 16/3 instance against a reference model.
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Large instances (32-bit, 32 entries) share one stimulus set.
  logic        rst = 1'b0;
  logic [4:0]  raddr0 = '0, raddr1 = '0, waddr0 = '0, waddr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] rd0_a, rd1_a, rd0_n, rd1_n;
  logic        busy_a, busy_n, conf_a, conf_n;

  // Small instance (16-bit, 8 entries) for the random run.
  logic        s_rst = 1'b0;
  logic [2:0]  s_raddr0 = '0, s_raddr1 = '0, s_waddr0 = '0, s_waddr1 = '0;
  logic [15:0] s_wdata0 = '0, s_wdata1 = '0;
  logic        s_we0 = 1'b0, s_we1 = 1'b0;
  logic [15:0] s_rd0, s_rd1;
  logic        s_busy, s_conf;

  reg_file_mp #(.XLEN(32), .AW(5), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_a), .rdata1(rd1_a),
    .waddr0(waddr0), .wdata0(wdata0), .we0(we0), .waddr1(waddr1), .wdata1(wdata1), .we1(we1),
    .busy(busy_a), .wr_conflict(conf_a));

  reg_file_mp #(.XLEN(32), .AW(5), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_n), .rdata1(rd1_n),
    .waddr0(waddr0), .wdata0(wdata0), .we0(we0), .waddr1(waddr1), .wdata1(wdata1), .we1(we1),
    .busy(busy_n), .wr_conflict(conf_n));

  reg_file_mp #(.XLEN(16), .AW(3), .BYPASS(1'b1)) dut_s (
    .clk(clk), .rst(s_rst), .raddr0(s_raddr0), .raddr1(s_raddr1), .rdata0(s_rd0), .rdata1(s_rd1),
    .waddr0(s_waddr0), .wdata0(s_wdata0), .we0(s_we0), .waddr1(s_waddr1), .wdata1(s_wdata1),
    .we1(s_we1), .busy(s_busy), .wr_conflict(s_conf));

  // Reference model for the small instance: contents, pending clear posedges, conflict flag.
  logic [15:0] ref_mem [8];
  int          ref_left = 0;
  logic        ref_conf = 1'b0;

  function automatic logic [15:0] ref_read(input logic [2:0] a);
    if (a == 3'd0 || ref_left > 0) return 16'h0;
    if (s_we1 && s_waddr1 == a) return s_wdata1;
    if (s_we0 && s_waddr0 == a) return s_wdata0;
    return ref_mem[a];
  endfunction

  task automatic test_reset();
    int cycles;
    @(negedge clk);
    raddr0 = 5'd4;
    #1;
    vectors++;
    if (busy_a !== 1'b0) begin miscompares++; $display("FAIL prereset_busy: got %0b want 0", busy_a); end
    vectors++;
    if (rd0_a !== 32'h0) begin miscompares++; $display("FAIL prereset_read: got %h want 0", rd0_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy_a !== 1'b1) begin miscompares++; $display("FAIL busy_on_rst: got %0b want 1", busy_a); end
    @(negedge clk);
    rst = 1'b0;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'hBEEF;
    raddr0 = 5'd5; raddr1 = 5'd0;
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 40) begin
      #1;
      vectors++;
      if (rd0_a !== 32'h0) begin miscompares++; $display("FAIL read_while_busy: got %h want 0", rd0_a); end
      vectors++;
      if (conf_a !== 1'b0) begin miscompares++; $display("FAIL conflict_in_clear: got %0b want 0", conf_a); end
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    vectors++;
    if (cycles != 31) begin miscompares++; $display("FAIL busy_len: got %0d want 31", cycles); end
    we0 = 1'b0; we1 = 1'b0;
    for (int i = 1; i < 32; i++) begin
      raddr0 = 5'(i);
      #1;
      vectors++;
      if (rd0_a !== 32'h0 || rd0_n !== 32'h0) begin
        miscompares++; $display("FAIL cleared_x%0d: got %h/%h want 0", i, rd0_a, rd0_n);
      end
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h12345678;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    raddr0 = 5'd3; raddr1 = 5'd0;
    #1;
    vectors++;
    if (rd1_a !== 32'h0) begin miscompares++; $display("FAIL x0_no_bypass: got %h want 0", rd1_a); end
    vectors++;
    if (rd0_n !== 32'h0) begin miscompares++; $display("FAIL nobypass_old: got %h want 0", rd0_n); end
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0;
    #1;
    vectors++;
    if (rd0_a !== 32'h12345678 || rd0_n !== 32'h12345678) begin
      miscompares++; $display("FAIL write_x3: got %h/%h want 12345678", rd0_a, rd0_n);
    end
    vectors++;
    if (rd1_n !== 32'h0) begin miscompares++; $display("FAIL write_x0: got %h want 0", rd1_n); end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA0000;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555FFFF;
    raddr0 = 5'd7;
    #1;
    vectors++;
    if (conf_a !== 1'b0) begin miscompares++; $display("FAIL conf_early: got %0b want 0", conf_a); end
    vectors++;
    if (rd0_a !== 32'h5555FFFF) begin miscompares++; $display("FAIL bypass_prio: got %h want 5555ffff", rd0_a); end
    @(posedge clk); #1;
    vectors++;
    if (conf_a !== 1'b1) begin miscompares++; $display("FAIL conf_pulse: got %0b want 1", conf_a); end
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0;
    #1;
    vectors++;
    if (rd0_n !== 32'h5555FFFF) begin miscompares++; $display("FAIL write_prio: got %h want 5555ffff", rd0_n); end
    @(posedge clk); #1;
    vectors++;
    if (conf_a !== 1'b0) begin miscompares++; $display("FAIL conf_one_cycle: got %0b want 0", conf_a); end
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd0; we1 = 1'b1; waddr1 = 5'd0;
    @(posedge clk); #1;
    vectors++;
    if (conf_a !== 1'b0) begin miscompares++; $display("FAIL conf_x0: got %0b want 0", conf_a); end
    @(negedge clk);
    waddr0 = 5'd10; wdata0 = 32'hA0A0; waddr1 = 5'd11; wdata1 = 32'hB1B1;
    @(posedge clk); #1;
    vectors++;
    if (conf_a !== 1'b0) begin miscompares++; $display("FAIL conf_diff_addr: got %0b want 0", conf_a); end
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0; raddr0 = 5'd10; raddr1 = 5'd11;
    #1;
    vectors++;
    if (rd0_n !== 32'hA0A0 || rd1_n !== 32'hB1B1) begin
      miscompares++; $display("FAIL dual_write: got %h/%h want a0a0/b1b1", rd0_n, rd1_n);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h1;
    @(negedge clk);
    wdata0 = 32'h2; raddr0 = 5'd9;
    #1;
    vectors++;
    if (rd0_a !== 32'h2) begin miscompares++; $display("FAIL bypass_on: got %h want 2", rd0_a); end
    vectors++;
    if (rd0_n !== 32'h1) begin miscompares++; $display("FAIL bypass_off: got %h want 1", rd0_n); end
    @(negedge clk);
    we0 = 1'b0;
    #1;
    vectors++;
    if (rd0_n !== 32'h2) begin miscompares++; $display("FAIL bypass_off_next: got %h want 2", rd0_n); end
    @(negedge clk);
    we0 = 1'b1; wdata0 = 32'h3; we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h4;
    #1;
    vectors++;
    if (rd0_a !== 32'h4 || rd0_n !== 32'h2) begin
      miscompares++; $display("FAIL bypass_both: got %h/%h want 4/2", rd0_a, rd0_n);
    end
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0;
    #1;
    vectors++;
    if (rd0_n !== 32'h4) begin miscompares++; $display("FAIL bypass_both_next: got %h want 4", rd0_n); end
  endtask

  task automatic test_midclear_reset();
    int cycles;
    for (int i = 1; i < 32; i += 2) begin
      @(negedge clk);
      we0 = 1'b1; waddr0 = 5'(i);     wdata0 = 32'(i);
      we1 = 1'b1; waddr1 = 5'(i + 1); wdata1 = 32'(i + 1);
    end
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0; raddr0 = 5'd10; raddr1 = 5'd31;
    #1;
    vectors++;
    if (rd0_n !== 32'd10 || rd1_n !== 32'd31) begin
      miscompares++; $display("FAIL fill: got %h/%h want a/1f", rd0_n, rd1_n);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    vectors++;
    if (busy_a !== 1'b1) begin miscompares++; $display("FAIL busy_midclear: got %0b want 1", busy_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 40) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    vectors++;
    if (cycles != 31) begin miscompares++; $display("FAIL restart_len: got %0d want 31", cycles); end
    for (int i = 1; i < 32; i++) begin
      raddr0 = 5'(i);
      #1;
      vectors++;
      if (rd0_n !== 32'h0) begin miscompares++; $display("FAIL reclear_x%0d: got %h want 0", i, rd0_n); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      s_rst    = (c == 0) || ($urandom_range(0, 63) == 0);
      s_we0    = 1'($urandom_range(0, 1));
      s_we1    = 1'($urandom_range(0, 1));
      s_waddr0 = 3'($urandom_range(0, 7));
      s_waddr1 = 3'($urandom_range(0, 7));
      s_wdata0 = 16'($urandom);
      s_wdata1 = 16'($urandom);
      s_raddr0 = 3'($urandom_range(0, 7));
      s_raddr1 = 3'($urandom_range(0, 7));
      #1;
      vectors++;
      if (s_rd0 !== ref_read(s_raddr0)) begin
        miscompares++; $display("FAIL rnd_rd0 c=%0d: got %h want %h", c, s_rd0, ref_read(s_raddr0));
      end
      vectors++;
      if (s_rd1 !== ref_read(s_raddr1)) begin
        miscompares++; $display("FAIL rnd_rd1 c=%0d: got %h want %h", c, s_rd1, ref_read(s_raddr1));
      end
      vectors++;
      if (s_busy !== (ref_left > 0)) begin
        miscompares++; $display("FAIL rnd_busy c=%0d: got %0b want %0b", c, s_busy, ref_left > 0);
      end
      vectors++;
      if (s_conf !== ref_conf) begin
        miscompares++; $display("FAIL rnd_conf c=%0d: got %0b want %0b", c, s_conf, ref_conf);
      end
      @(posedge clk);
      if (s_rst) begin
        ref_left = 7;
        ref_conf = 1'b0;
      end else if (ref_left > 0) begin
        ref_mem[8 - ref_left] = 16'h0;
        ref_left--;
        ref_conf = 1'b0;
      end else begin
        ref_conf = s_we0 && s_we1 && (s_waddr0 == s_waddr1) && (s_waddr0 != 3'd0);
        if (s_we0 && s_waddr0 != 3'd0) ref_mem[s_waddr0] = s_wdata0;
        if (s_we1 && s_waddr1 != 3'd0) ref_mem[s_waddr1] = s_wdata1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_conflict();
    test_bypass();
    test_midclear_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
